vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
// - Parametrised VGA raster timing generator; replaces hard-coded 640x480 h/v counters in game blocks.
// - Produces pixel coordinates, data-enable, polarity-configurable syncs, line/frame/vblank strobes.
// - Produces a game tick every TICK_FRAMES frames; sits between the clock/reset block and pixel renderers.
// PARAMETERS
// - H_ACTIVE     640  visible pixels per line
// - H_FP         16   h front porch, pixels
// - H_SYNC       96   h sync width, pixels
// - H_BP         48   h back porch, pixels
// - V_ACTIVE     480  visible lines per frame
// - V_FP         10   v front porch, lines
// - V_SYNC       2    v sync width, lines
// - V_BP         33   v back porch, lines
// - HS_POL       0    hsync active level (0 = active-low)
// - VS_POL       0    vsync active level (0 = active-low)
// - TICK_FRAMES  1    frames per game_tick pulse, >=1
// - XW           10   x width; must hold H_TOTAL-1 (H_TOTAL = sum of H_* params)
// - YW           10   y width; must hold V_TOTAL-1 (V_TOTAL = sum of V_* params)
// PORTS
// - clk           in   1   clock
// - rst           in   1   synchronous, active-high reset
// - ce            in   1   pixel enable; raster advances one pixel per clk with ce=1
// - x             out  XW  current h position, 0..H_TOTAL-1
// - y             out  YW  current line, 0..V_TOTAL-1
// - de            out  1   1 when x<H_ACTIVE and y<V_ACTIVE
// - hsync         out  1   HS_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC
// - vsync         out  1   VS_POL when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (whole lines, x-independent)
// - line_start    out  1   one-clk strobe, pixel x=0 presented
// - frame_start   out  1   one-clk strobe, pixel (0,0) presented
// - vblank_start  out  1   one-clk strobe, pixel (0,V_ACTIVE) presented
// - game_tick     out  1   one-clk strobe on every TICK_FRAMES-th vblank_start
// - frame_count   out  8   increments at each frame_start, wraps 255->0
// BEHAVIOUR
// - All outputs registered; x,y,de,hsync,vsync mutually aligned, describing the same pixel.
// - Reset: x=0, y=0, de=0, hsync=!HS_POL, vsync=!VS_POL, all strobes 0, frame_count=0, tick divider=0.
// - Reset: internal position = (H_TOTAL-1, V_TOTAL-1); first ce=1 clk after rst release presents (0,0)
//   with frame_start=1, line_start=1, de=1; frame_count stays 0 at that first frame_start.
// - Advance on ce=1: x+1; at x=H_TOTAL-1 -> x=0, y+1; at y=V_TOTAL-1 also -> y=0 (frame wrap).
// - ce=0: x,y,de,hsync,vsync,frame_count hold; strobes forced 0 (strobe high exactly one clk).
// - Latency: outputs update on the clk edge where ce=1 is sampled; zero extra pipeline.
// - Tick divider 0..TICK_FRAMES-1 advances on each vblank_start; game_tick when divider wraps to 0,
//   so first game_tick at first vblank_start after reset, then every TICK_FRAMES frames.
// - TICK_FRAMES=1: game_tick coincides with every vblank_start.
// - Simultaneous rst and ce: rst wins. rst mid-frame: next clk shows reset values, restart as above.
// - Strobes derive from the next position, never from stale registered outputs.
// TESTING
// - Default params, ce=1 after reset -> frame_start at clk 1; next frame_start exactly 420000 clks later.
// - Line scan -> de high 640 clks per active line; hsync low x=656..751 (96 clks); line period 800.
// - Frame scan -> vsync low for y=490..491 (1600 clks); de=0 for y>=480; vblank_start at (0,480).
// - TICK_FRAMES=3, HS_POL=VS_POL=1 -> game_tick every 1260000 clks; syncs active-high.
// - ce toggling 1,0,... -> all periods doubled; strobes 1 clk wide; x,y frozen while ce=0.
// - Small params (H 4/1/2/1, V 3/1/1/1): rst at (5,2) -> reset values next clk, then (0,0) frame_start.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between the raster generator (master) and pixel renderers (slave).
// ce qualifies every clk: the raster advances one pixel on each clk where ce=1 and holds otherwise.
interface vga_timing_gen_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic          ce;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          de;
  logic          hsync;
  logic          vsync;
  logic          line_start;
  logic          frame_start;
  logic          vblank_start;
  logic          game_tick;
  logic [7:0]    frame_count;

  modport master (
    input  ce,
    output x, y, de, hsync, vsync,
    output line_start, frame_start, vblank_start, game_tick, frame_count
  );

  modport slave (
    output ce,
    input  x, y, de, hsync, vsync,
    input  line_start, frame_start, vblank_start, game_tick, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: coordinates, data-enable, syncs,
// line/frame/vblank strobes, frame counter and a game tick every TICK_FRAMES frames.
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int TICK_FRAMES = 1,
  parameter int XW          = 10,
  parameter int YW          = 10
) (
  input  logic               clk,
  input  logic               rst,
  vga_timing_gen_if.master   vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int TW      = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;

  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_SB   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_SE   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_SB   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] V_SE   = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [TW-1:0] T_LAST = TW'(TICK_FRAMES - 1);

  // Internal position sits on the last pixel after reset so the first ce lands on (0,0).
  logic [XW-1:0] h_pos, h_nxt;
  logic [YW-1:0] v_pos, v_nxt;
  logic          h_wrap;
  logic          nxt_line, nxt_frame, nxt_vblank;
  logic          first_frame;
  logic [TW-1:0] tick_div;

  always_comb begin
    h_wrap     = (h_pos == H_LAST);
    h_nxt      = h_wrap ? '0 : h_pos + 1'b1;
    v_nxt      = v_pos;
    if (h_wrap) v_nxt = (v_pos == V_LAST) ? '0 : v_pos + 1'b1;
    nxt_line   = (h_nxt == '0);
    nxt_frame  = nxt_line && (v_nxt == '0);
    nxt_vblank = nxt_line && (v_nxt == V_ACT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_pos            <= H_LAST;
      v_pos            <= V_LAST;
      first_frame      <= 1'b1;
      tick_div         <= '0;
      vid.x            <= '0;
      vid.y            <= '0;
      vid.de           <= 1'b0;
      vid.hsync        <= ~HS_POL;
      vid.vsync        <= ~VS_POL;
      vid.line_start   <= 1'b0;
      vid.frame_start  <= 1'b0;
      vid.vblank_start <= 1'b0;
      vid.game_tick    <= 1'b0;
      vid.frame_count  <= '0;
    end else begin
      vid.line_start   <= 1'b0;
      vid.frame_start  <= 1'b0;
      vid.vblank_start <= 1'b0;
      vid.game_tick    <= 1'b0;
      if (vid.ce) begin
        h_pos            <= h_nxt;
        v_pos            <= v_nxt;
        vid.x            <= h_nxt;
        vid.y            <= v_nxt;
        vid.de           <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
        vid.hsync        <= ((h_nxt >= H_SB) && (h_nxt < H_SE)) ? HS_POL : ~HS_POL;
        vid.vsync        <= ((v_nxt >= V_SB) && (v_nxt < V_SE)) ? VS_POL : ~VS_POL;
        vid.line_start   <= nxt_line;
        vid.frame_start  <= nxt_frame;
        vid.vblank_start <= nxt_vblank;
        first_frame      <= 1'b0;
        // The frame presented right after reset is frame 0, so it does not count.
        if (nxt_frame && !first_frame) vid.frame_count <= vid.frame_count + 8'd1;
        if (nxt_vblank) begin
          vid.game_tick <= (tick_div == '0);
          tick_div      <= (tick_div == T_LAST) ? '0 : tick_div + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-raster instances, a hand-derived vector table,
// corner-case sequences and random ce/rst traffic against a pixel-index reference model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       de, hs, vs, ls, fs, vb, gt;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, tick;
    bit hpol, vpol;
  } prm_t;

  typedef struct {
    logic rst;
    logic ce;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;
  int   n_vec  = 0;
  int   n_miss = 0;

  // Reference state: pixel index presented since the last reset, shared by both rasters.
  bit   m_started = 1'b0;
  bit   m_adv     = 1'b0;
  int   m_idx     = 0;
  prm_t pa, pb;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.XW(3), .YW(3)) if_a ();
  vga_timing_gen_if #(.XW(4), .YW(4)) if_b ();
  assign if_a.ce = ce;
  assign if_b.ce = ce;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .TICK_FRAMES(1), .XW(3), .YW(3)
  ) dut_a (.clk(clk), .rst(rst), .vid(if_a));

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .TICK_FRAMES(3), .XW(4), .YW(4)
  ) dut_b (.clk(clk), .rst(rst), .vid(if_b));

  function automatic obs_t mk(input int x, input int y, input bit de, input bit hs, input bit vs,
                              input bit ls, input bit fs, input bit vb, input bit gt, input int fc);
    obs_t o;
    o.x = 8'(x); o.y = 8'(y);
    o.de = de; o.hs = hs; o.vs = vs; o.ls = ls; o.fs = fs; o.vb = vb; o.gt = gt;
    o.fc = 8'(fc);
    return o;
  endfunction

  function automatic obs_t model(input prm_t p, input bit started, input bit adv, input int idx);
    obs_t o;
    int ht, vt, x, y, f;
    o = '0;
    if (!started) begin
      o.hs = ~p.hpol;
      o.vs = ~p.vpol;
      return o;
    end
    ht = p.ha + p.hf + p.hs + p.hb;
    vt = p.va + p.vf + p.vs + p.vb;
    x  = idx % ht;
    y  = (idx / ht) % vt;
    f  = idx / (ht * vt);
    o.x  = 8'(x);
    o.y  = 8'(y);
    o.de = (x < p.ha) && (y < p.va);
    o.hs = ((x >= p.ha + p.hf) && (x < p.ha + p.hf + p.hs)) ? p.hpol : ~p.hpol;
    o.vs = ((y >= p.va + p.vf) && (y < p.va + p.vf + p.vs)) ? p.vpol : ~p.vpol;
    o.ls = adv && (x == 0);
    o.fs = o.ls && (y == 0);
    o.vb = o.ls && (y == p.va);
    o.gt = o.vb && ((f % p.tick) == 0);
    o.fc = 8'(f % 256);
    return o;
  endfunction

  function automatic obs_t obs_a();
    return mk(int'(if_a.x), int'(if_a.y), if_a.de, if_a.hsync, if_a.vsync, if_a.line_start,
              if_a.frame_start, if_a.vblank_start, if_a.game_tick, int'(if_a.frame_count));
  endfunction

  function automatic obs_t obs_b();
    return mk(int'(if_b.x), int'(if_b.y), if_b.de, if_b.hsync, if_b.vsync, if_b.line_start,
              if_b.frame_start, if_b.vblank_start, if_b.game_tick, int'(if_b.frame_count));
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b vb=%b gt=%b fc=%0d, want x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b vb=%b gt=%b fc=%0d",
               name, $time, got.x, got.y, got.de, got.hs, got.vs, got.ls, got.fs, got.vb, got.gt, got.fc,
               exp.x, exp.y, exp.de, exp.hs, exp.vs, exp.ls, exp.fs, exp.vb, exp.gt, exp.fc);
    end
  endtask

  task automatic step(input logic r, input logic c);
    @(negedge clk);
    rst = r;
    ce  = c;
    @(posedge clk);
    #1;
    if (r) begin
      m_started = 1'b0; m_adv = 1'b0; m_idx = 0;
    end else if (c) begin
      if (!m_started) begin m_started = 1'b1; m_idx = 0; end
      else m_idx++;
      m_adv = 1'b1;
    end else begin
      m_adv = 1'b0;
    end
    check("model_a", obs_a(), model(pa, m_started, m_adv, m_idx));
    check("model_b", obs_b(), model(pb, m_started, m_adv, m_idx));
  endtask

  vec_t tbl[12];

  initial begin
    pa = '{ha:4, hf:1, hs:2, hb:1, va:3, vf:1, vs:1, vb:1, tick:1, hpol:1'b0, vpol:1'b0};
    pb = '{ha:6, hf:2, hs:3, hb:2, va:4, vf:1, vs:2, vb:2, tick:3, hpol:1'b1, vpol:1'b1};

    // Raster A: 8 clocks per line, 6 lines per frame, active-low syncs at x=5..6 and y=4.
    tbl[0]  = '{1'b1, 1'b1, mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1'b0, 1'b0, mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0)};
    tbl[2]  = '{1'b0, 1'b1, mk(0, 0, 1, 1, 1, 1, 1, 0, 0, 0)};
    tbl[3]  = '{1'b0, 1'b1, mk(1, 0, 1, 1, 1, 0, 0, 0, 0, 0)};
    tbl[4]  = '{1'b0, 1'b0, mk(1, 0, 1, 1, 1, 0, 0, 0, 0, 0)};
    tbl[5]  = '{1'b0, 1'b1, mk(2, 0, 1, 1, 1, 0, 0, 0, 0, 0)};
    tbl[6]  = '{1'b0, 1'b1, mk(3, 0, 1, 1, 1, 0, 0, 0, 0, 0)};
    tbl[7]  = '{1'b0, 1'b1, mk(4, 0, 0, 1, 1, 0, 0, 0, 0, 0)};
    tbl[8]  = '{1'b0, 1'b1, mk(5, 0, 0, 0, 1, 0, 0, 0, 0, 0)};
    tbl[9]  = '{1'b0, 1'b1, mk(6, 0, 0, 0, 1, 0, 0, 0, 0, 0)};
    tbl[10] = '{1'b0, 1'b1, mk(7, 0, 0, 1, 1, 0, 0, 0, 0, 0)};
    tbl[11] = '{1'b0, 1'b1, mk(0, 1, 1, 1, 1, 1, 0, 0, 0, 0)};

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].ce);
      check($sformatf("tbl%0d", i), obs_a(), tbl[i].exp);
    end

    // Reset in mid-frame at (5,2), then restart at (0,0).
    repeat (13) step(1'b0, 1'b1);
    check("at_5_2", obs_a(), mk(5, 2, 0, 0, 1, 0, 0, 0, 0, 0));
    step(1'b1, 1'b1);
    check("rst_mid", obs_a(), mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    step(1'b0, 1'b1);
    check("restart", obs_a(), mk(0, 0, 1, 1, 1, 1, 1, 0, 0, 0));

    // First vblank_start also carries the first game tick.
    repeat (24) step(1'b0, 1'b1);
    check("vblank", obs_a(), mk(0, 3, 0, 1, 1, 1, 0, 1, 1, 0));
    step(1'b0, 1'b0);
    check("vb_hold", obs_a(), mk(0, 3, 0, 1, 1, 0, 0, 0, 0, 0));
    repeat (8) step(1'b0, 1'b1);
    check("vsync_on", obs_a(), mk(0, 4, 0, 1, 0, 1, 0, 0, 0, 0));
    repeat (16) step(1'b0, 1'b1);
    check("frame1", obs_a(), mk(0, 0, 1, 1, 1, 1, 1, 0, 0, 1));

    // Long random-ce run: enough frames to wrap frame_count on raster A.
    repeat (20000) step(1'b0, logic'($urandom_range(0, 3) != 0));
    repeat (3000) step(logic'($urandom_range(0, 999) == 0), logic'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
